div6_seq: RTL

Sequential 6-bit unsigned restoring divider for the arithmetic library. It reuses the 6-bit add/subtract datapath style: each iteration performs one trial subtraction. It computes one quotient bit per clock, with a start/busy/done handshake, so a controller can issue divisions without a combinational divider in its path. Its typical consumers are small controllers that need A/B and A mod B on 6-bit operands.

---
 rtl/div6_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/div6_seq.sv
`default_nettype none
// ============================================================================
// Module   : div6_seq
// Brief    : 6-bit unsigned restoring divider, one quotient bit per clock,
//            start/busy/done handshake, divide-by-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module div6_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] A,
  input  logic [5:0] B,
  output logic [5:0] Q,
  output logic [5:0] R,
  output logic       busy,
  output logic       done,
  output logic       div0
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] C_LAST_ITER = 3'd5;
  localparam logic [5:0] C_DIV0_Q    = 6'h3F;

  state_t     r_state;
  state_t     w_next;

  logic [5:0] r_dvd;
  logic [5:0] r_dvs;
  logic [5:0] r_quo;
  logic [6:0] r_rem;
  logic [2:0] r_cnt;
  logic [5:0] r_q;
  logic [5:0] r_r;
  logic       r_div0;

  logic       w_accept;
  logic       w_bzero;
  logic       w_last;
  logic [6:0] w_t;
  logic [7:0] w_d;
  logic       w_borrow;
  logic [6:0] w_rem_nxt;
  logic [5:0] w_quo_nxt;
  logic       w_unused;

  assign w_accept  = start && (r_state != S_RUN);
  assign w_bzero   = (B == 6'd0);
  assign w_last    = (r_cnt == C_LAST_ITER);

  // Trial subtraction: the remainder is always < divisor, so its top bit is
  // never needed when forming the shifted value.
  assign w_t       = {r_rem[5:0], r_dvd[5]};
  assign w_d       = {1'b0, w_t} - {2'b00, r_dvs};
  assign w_borrow  = w_d[7];
  assign w_rem_nxt = w_borrow ? w_t : w_d[6:0];
  assign w_quo_nxt = {r_quo[4:0], ~w_borrow};
  assign w_unused  = r_rem[6];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; DONE behaves like IDLE for a new request
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_next = S_IDLE;
        if (start) begin
          w_next = w_bzero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd  <= 6'd0;
      r_dvs  <= 6'd0;
      r_quo  <= 6'd0;
      r_rem  <= 7'd0;
      r_cnt  <= 3'd0;
      r_q    <= 6'd0;
      r_r    <= 6'd0;
      r_div0 <= 1'b0;
    end else if (w_accept) begin
      if (w_bzero) begin
        r_q    <= C_DIV0_Q;
        r_r    <= A;
        r_div0 <= 1'b1;
      end else begin
        r_dvd  <= A;
        r_dvs  <= B;
        r_rem  <= 7'd0;
        r_quo  <= 6'd0;
        r_cnt  <= 3'd0;
      end
    end else if (r_state == S_RUN) begin
      r_dvd <= {r_dvd[4:0], 1'b0};
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 3'd1;
      if (w_last) begin
        r_q    <= w_quo_nxt;
        r_r    <= w_rem_nxt[5:0];
        r_div0 <= 1'b0;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign Q    = r_q;
  assign R    = r_r;
  assign div0 = r_div0;

endmodule
`default_nettype wire
